reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_sequencer_if.sv | 41 ++++
 rtl/sync_2ff.sv | 27 ++
 rtl/reset_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Holds the sequencer state enum, its width, the loss-counter width and a counter sizing helper.
package reset_seq_pkg;

  localparam int STATE_W    = 2;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  // clog2 of the larger of two cycle counts, never below one bit
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's lock/request inputs and staged reset outputs.
// slave: sequencer side; master: environment side. lock_loss_cnt only with RESET_SEQ_LOSS_CNT_EN.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_LOCKS   = 2,
  parameter int NUM_DOMAINS = 4
);

  logic [NUM_LOCKS-1:0]   pll_lock;
  logic                   sw_reset_req;
  logic [NUM_DOMAINS-1:0] domain_reset_n;
  logic                   all_released;
  logic [STATE_W-1:0]     seq_state;
`ifdef RESET_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0]  lock_loss_cnt;
`endif

  modport slave (
    input  pll_lock,
    input  sw_reset_req,
`ifdef RESET_SEQ_LOSS_CNT_EN
    output lock_loss_cnt,
`endif
    output domain_reset_n,
    output all_released,
    output seq_state
  );

  modport master (
    output pll_lock,
    output sw_reset_req,
`ifdef RESET_SEQ_LOSS_CNT_EN
    input  lock_loss_cnt,
`endif
    input  domain_reset_n,
    input  all_released,
    input  seq_state
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a vector of independent asynchronous flags.
// Ports: i_clk, i_rst (async, active-high), i_d (async flags), o_q (synchronized flags).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: waits for all PLL locks, holds, then frees domains in ascending order.
// Ports: clk0012p0, user_reset_button (async, active-high), bus (reset_sequencer_if.slave).
// Optional RESET_SEQ_LOSS_CNT_EN adds a saturating lock-loss counter on bus.lock_loss_cnt.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_LOCKS    = 2,
  parameter int NUM_DOMAINS  = 4,
  parameter int HOLD_CYCLES  = 120,
  parameter int STAGE_CYCLES = 12
) (
  input  logic               clk0012p0,
  input  logic               user_reset_button,
  reset_sequencer_if.slave   bus
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

  logic [NUM_LOCKS-1:0]   w_lock_sync;
  logic                   w_lock_ok;
  seq_state_e             r_state;
  seq_state_e             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [NUM_DOMAINS-1:0] r_dom_n;
  logic [NUM_DOMAINS-1:0] w_dom_nxt;
  logic [NUM_DOMAINS-1:0] w_dom_shift;
  logic                   r_all_rel;

  sync_2ff #(
    .WIDTH (NUM_LOCKS)
  ) u_sync (
    .i_clk (clk0012p0),
    .i_rst (user_reset_button),
    .i_d   (bus.pll_lock),
    .o_q   (w_lock_sync)
  );

  assign w_lock_ok = &w_lock_sync;

  // released domains form a thermometer code; the next release shifts in a 1
  assign w_dom_shift = (r_dom_n << 1) | NUM_DOMAINS'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dom_nxt   = r_dom_n;
    unique case (r_state)
      ASSERT: begin
        w_cnt_nxt = '0;
        w_dom_nxt = '0;
        if (w_lock_ok) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (!w_lock_ok) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = '0;
          w_dom_nxt   = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_dom_nxt   = NUM_DOMAINS'(1);
          w_state_nxt = (NUM_DOMAINS == 1) ? RUN : RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!w_lock_ok) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = '0;
          w_dom_nxt   = '0;
        end else if (r_cnt == STAGE_LAST) begin
          w_cnt_nxt = '0;
          w_dom_nxt = w_dom_shift;
          if (w_dom_shift[NUM_DOMAINS-1]) w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lock_ok || bus.sw_reset_req) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = '0;
          w_dom_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ASSERT;
        w_cnt_nxt   = '0;
        w_dom_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk0012p0 or posedge user_reset_button) begin
    if (user_reset_button) begin
      r_state   <= ASSERT;
      r_cnt     <= '0;
      r_dom_n   <= '0;
      r_all_rel <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dom_n   <= w_dom_nxt;
      r_all_rel <= (w_state_nxt == RUN);
    end
  end

  assign bus.domain_reset_n = r_dom_n;
  assign bus.all_released   = r_all_rel;
  assign bus.seq_state      = r_state;

`ifdef RESET_SEQ_LOSS_CNT_EN
  logic                  w_loss;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // a lock loss only counts once the sequence has left ASSERT
  assign w_loss = !w_lock_ok && (r_state != ASSERT);

  always_ff @(posedge clk0012p0 or posedge user_reset_button) begin
    if (user_reset_button) begin
      r_loss_cnt <= '0;
    end else if (w_loss && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign bus.lock_loss_cnt = r_loss_cnt;
`endif

endmodule
